// File: rtl/sender_ram.sv
// Sender-path single-port RAM: registered reads with a valid strobe, per-byte writes,
// and a full-array zero sweep after reset or on request, flagged by Busy.
module sender_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ReadEnable,
    input  logic                  WriteEnable,
    input  logic                  ClearStart,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [BE_WIDTH-1:0]   ByteEnable,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  Busy
);

    localparam int unsigned           DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_fire;

    // Expand the byte enables into a bit mask; lanes only count when a write is requested.
    for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
        assign lane_mask[8*g +: 8] = {8{WriteEnable & ByteEnable[g]}};
    end

    // Write-first merge: the word a same-cycle read returns is the post-write value.
    assign merged_word = (mem[Address] & ~lane_mask) | (DataIn & lane_mask);

    // Next-state and array-port control.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_addr   = Address;
        mem_wdata  = merged_word;
        rd_fire    = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = '0;
                ptr_next  = ptr + ADDR_WIDTH'(1);
                if (ptr == PTR_LAST) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (ClearStart) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end else begin
                    mem_we  = WriteEnable;
                    rd_fire = ReadEnable;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // The array is left untouched while reset is held; the sweep clears it afterwards.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            DataOut   <= '0;
            DataValid <= 1'b0;
            Busy      <= 1'b1;
        end else begin
            DataValid <= rd_fire;
            Busy      <= (state_next == CLEAR);
            if (rd_fire) begin
                DataOut <= merged_word;
            end
        end
    end

endmodule

// File: tb/tb_sender_ram.sv
// Bench for sender_ram: directed scenarios plus random idle traffic, all checked
// against a word-array model with a sweep countdown.
module tb_sender_ram;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ReadEnable;
    logic          WriteEnable;
    logic          ClearStart;
    logic [AW-1:0] Address;
    logic [BW-1:0] ByteEnable;
    logic [DW-1:0] DataIn;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic          Busy;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [DW-1:0] model_mem [DEPTH];
    int            clear_left = 0;
    logic [DW-1:0] exp_dout   = '0;
    logic          exp_dv     = 1'b0;

    sender_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ReadEnable (ReadEnable),
        .WriteEnable(WriteEnable),
        .ClearStart (ClearStart),
        .Address    (Address),
        .ByteEnable (ByteEnable),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .DataValid  (DataValid),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model by one edge, return at the falling edge.
    task automatic step(input logic r, input logic re, input logic we, input logic cs,
                        input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        rst = r; ReadEnable = re; WriteEnable = we; ClearStart = cs;
        Address = a; ByteEnable = be; DataIn = d;
        @(posedge clk);
        if (r) begin
            clear_left = DEPTH;
            exp_dout   = '0;
            exp_dv     = 1'b0;
        end else if (clear_left > 0) begin
            clear_left--;
            for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
            exp_dv = 1'b0;
        end else if (cs) begin
            clear_left = DEPTH;
            exp_dv     = 1'b0;
        end else begin
            if (we) begin
                for (int i = 0; i < BW; i++)
                    if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
            end
            if (re) exp_dout = model_mem[a];
            exp_dv = re;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        int cnt;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 4'(c), '1, 16'hBEEF);
            total++; if (DataOut !== 16'h0000) begin bad++; $display("FAIL reset_dout got=%h exp=0000", DataOut); end
            total++; if (DataValid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", DataValid); end
            total++; if (Busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", Busy); end
        end
        cnt = 0;
        while (Busy === 1'b1 && cnt < 64) begin
            cnt++;
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'($urandom), '1, 16'hFFFF);
            total++; if (DataValid !== 1'b0) begin bad++; $display("FAIL reset_sweep_dv got=%b exp=0", DataValid); end
        end
        total++; if (cnt != 16) begin bad++; $display("FAIL reset_busy_len got=%0d exp=16", cnt); end
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'(a), '0, '0);
            total++; if (DataOut !== 16'h0000 || DataValid !== 1'b1)
                begin bad++; $display("FAIL reset_read a=%0d got=%h/%b exp=0000/1", a, DataOut, DataValid); end
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 2'b11, 16'hA5C3);
        total++; if (DataValid !== 1'b0) begin bad++; $display("FAIL wr_dv got=%b exp=0", DataValid); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 2'b00, 16'h0000);
        total++; if (DataOut !== 16'hA5C3 || DataValid !== 1'b1)
            begin bad++; $display("FAIL wr_rd got=%h/%b exp=a5c3/1", DataOut, DataValid); end
        idle();
        total++; if (DataOut !== 16'hA5C3 || DataValid !== 1'b0)
            begin bad++; $display("FAIL wr_hold got=%h/%b exp=a5c3/0", DataOut, DataValid); end
    endtask

    task automatic test_byte_lanes();
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 2'b11, 16'h1234);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 2'b01, 16'hABCD);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 2'b00, 16'h5555);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 2'b00, 16'h0000);
        total++; if (DataOut !== 16'h12CD) begin bad++; $display("FAIL lanes got=%h exp=12cd", DataOut); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 2'b10, 16'hEE99);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 2'b00, 16'h0000);
        total++; if (DataOut !== 16'hEECD) begin bad++; $display("FAIL lanes_hi got=%h exp=eecd", DataOut); end
    endtask

    task automatic test_simul_rw();
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 2'b11, 16'h00FF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 2'b10, 16'h7700);
        total++; if (DataOut !== 16'h77FF || DataValid !== 1'b1)
            begin bad++; $display("FAIL rw_same got=%h/%b exp=77ff/1", DataOut, DataValid); end
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 2'b00, 16'h0000);
        total++; if (DataOut !== 16'h77FF) begin bad++; $display("FAIL rw_later got=%h exp=77ff", DataOut); end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < DEPTH; a++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'(a), 2'b11, 16'(a * 16'h1111 + 3));
        for (int a = DEPTH - 1; a >= 0; a--) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'(a), 2'b00, 16'h0000);
            total++; if (DataOut !== exp_dout || DataValid !== 1'b1)
                begin bad++; $display("FAIL b2b a=%0d got=%h/%b exp=%h/1", a, DataOut, DataValid, exp_dout); end
        end
    endtask

    task automatic test_clear_under_load();
        int cnt;
        for (int a = 0; a < DEPTH; a++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'(a), 2'b11, 16'hFFFF);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 2'b11, 16'h1234);
        total++; if (DataValid !== 1'b0) begin bad++; $display("FAIL clr_start_dv got=%b exp=0", DataValid); end
        cnt = 0;
        while (Busy === 1'b1 && cnt < 64) begin
            cnt++;
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'($urandom), '0, '0);
            total++; if (DataValid !== 1'b0) begin bad++; $display("FAIL clr_busy_dv got=%b exp=0", DataValid); end
        end
        total++; if (cnt != 16) begin bad++; $display("FAIL clr_busy_len got=%0d exp=16", cnt); end
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'(a), '0, '0);
            total++; if (DataOut !== 16'h0000 || DataValid !== 1'b1)
                begin bad++; $display("FAIL clr_read a=%0d got=%h/%b exp=0000/1", a, DataOut, DataValid); end
        end
    endtask

    task automatic test_reset_midsweep();
        int cnt;
        for (int a = 0; a < DEPTH; a += 3)
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'(a), 2'b11, 16'($urandom) | 16'h0101);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        for (int c = 0; c < 9; c++) begin
            idle();
            total++; if (Busy !== 1'b1) begin bad++; $display("FAIL mid_busy c=%0d got=%b exp=1", c, Busy); end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 64) begin
            cnt++;
            idle();
        end
        total++; if (cnt != 16) begin bad++; $display("FAIL mid_busy_len got=%0d exp=16", cnt); end
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'(a), '0, '0);
            total++; if (DataOut !== 16'h0000) begin bad++; $display("FAIL mid_read a=%0d got=%h exp=0000", a, DataOut); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 39) == 0),
                 4'($urandom), 2'($urandom), 16'($urandom));
            total++; if (DataValid !== exp_dv) begin bad++; $display("FAIL rnd_dv n=%0d got=%b exp=%b", n, DataValid, exp_dv); end
            total++; if (DataOut !== exp_dout) begin bad++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, DataOut, exp_dout); end
            total++; if (Busy !== (clear_left > 0)) begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, Busy, clear_left > 0); end
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_simul_rw();
        test_back_to_back();
        test_clear_under_load();
        test_reset_midsweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sender_ram.md
# sender_ram

Parametrised, synchronous single-port RAM for the sender path; the next generation of the 16×16 sender memory. Width, depth and byte-lane count are parametrised. Reads are registered with a valid strobe, writes take per-byte enables, and the array self-clears on reset or on request with a busy indication. It sits between the sender control FSM and the serialiser, holding the outgoing frame words.

## Interface

Reset is synchronous and active-high.

- DATA_WIDTH, 16, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
- BE_WIDTH, DATA_WIDTH/8, derived, number of byte lanes; not to be overridden
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ReadEnable  input  1  read request, sampled on clk edge
- WriteEnable  input  1  write request, sampled on clk edge
- ClearStart  input  1  request a full-array zero sweep
- Address  input  ADDR_WIDTH  word address shared by read and write
- ByteEnable  input  BE_WIDTH  write lane mask; bit i covers DataIn[8i+7:8i]
- DataIn  input  DATA_WIDTH  write data
- DataOut  output  DATA_WIDTH  registered read data; holds the last read value
- DataValid  output  1  one-cycle strobe; DataOut was updated on the same edge
- Busy  output  1  clear sweep in progress; all requests are ignored

## Operation

- States: CLEAR, IDLE.
  - CLEAR: sweeps the array, holding Busy.
  - IDLE: serves read and write requests.
- Reset:
  - While rst=1: state=CLEAR, clear pointer=0, DataOut=0, DataValid=0, Busy=1.
  - The array itself is not written while rst=1.
- CLEAR:
  - Each edge with rst=0 writes 0 to mem[pointer] and increments the pointer.
  - After the write to DEPTH-1, go to IDLE; the pointer wraps to 0.
  - ReadEnable, WriteEnable, ClearStart and ByteEnable are ignored.
  - DataValid stays 0 and DataOut holds its value.
- IDLE, per edge:
  - ClearStart=1 has priority. Go to CLEAR with pointer=0. Read and write in the same cycle are dropped.
  - WriteEnable=1: mem[Address] lane i <= DataIn lane i for each ByteEnable[i]=1. Other lanes are unchanged. ByteEnable=0 writes nothing but is still a legal cycle.
  - ReadEnable=1: DataOut <= mem[Address] and DataValid <= 1.
  - Both enables high: the write is performed and DataOut returns the merged post-write word (write-first). Unenabled lanes come from the old contents.
  - Neither enable high: DataValid <= 0 and DataOut holds.
- A mid-sweep rst restarts the sweep from address 0 once rst falls.
- Address beyond DEPTH cannot occur; it is masked by width.

## Timing

- Read latency is 1 clk.
  - Request sampled at edge k; DataOut and DataValid are valid after edge k.
  - DataValid falls after edge k+1 unless another read is sampled at k+1.
- Back-to-back reads are supported: one result per cycle, with DataValid held high continuously.
- Write latency:
  - The write is committed at the sampling edge.
  - A read of the same address at edge k+1 returns the new data.
- Clear duration: Busy=1 for exactly DEPTH edges after rst falls or after ClearStart is sampled.
  - On the edge after ClearStart is sampled, Busy rises (registered).
  - Busy falls on the edge that writes address DEPTH-1.
  - A request in the first cycle with Busy=0 is served.
- Busy after reset: rst low at edge 0 puts the zero-writes at edges 0..DEPTH-1. Busy=0 from edge DEPTH-1 onward (16 edges with defaults).
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan

- Reset/clear:
  - Stimulus: assert rst 3 cycles, release.
  - Response: Busy=1 for exactly 16 edges, then 0.
  - Reading all 16 addresses then gives DataOut=16'h0000 with DataValid=1 each cycle.
  - DataOut=0 and DataValid=0 during reset.
- Write/read:
  - Stimulus: write 16'hA5C3 to address 7 with ByteEnable=2'b11, then read address 7 the next cycle.
  - Response: DataOut=16'hA5C3 with DataValid=1 one cycle after the read request. DataOut holds while idle.
- Byte lanes:
  - Stimulus: write 16'h1234 to address 2 with ByteEnable=11, then write 16'hABCD with ByteEnable=01, then read.
  - Response: DataOut=16'h12CD.
- Simultaneous R/W:
  - Setup: address 5 holds 16'h00FF.
  - Stimulus: one cycle with ReadEnable=WriteEnable=1, DataIn=16'h7700, ByteEnable=10.
  - Response: DataOut=16'h77FF and DataValid=1; a later read also returns 16'h77FF.
- Clear under load:
  - Stimulus: fill addresses 0..15 with 16'hFFFF, then pulse ClearStart together with WriteEnable=1 to address 3.
  - Response: the write is dropped and Busy=1 for 16 edges. Reads issued during Busy give no DataValid. Afterwards all words read 16'h0000.
- Reset mid-sweep:
  - Stimulus: assert rst at sweep pointer 9 for 1 cycle.
  - Response: the sweep restarts and Busy stays high 16 more edges after rst falls; the array ends all-zero.
